// File: rtl/seq_mem_pipe_d2.sv
// Single-port 2-D sequential memory with a READ_LATENCY-deep read pipeline and address checking.
// Define SEQ_MEM_PIPE_BYPASS_EN to forward in-flight writes into pending reads.
module seq_mem_pipe_d2 #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned D0_SIZE      = 8,
  parameter int unsigned D1_SIZE      = 8,
  parameter int unsigned D0_IDX_SIZE  = 4,
  parameter int unsigned D1_IDX_SIZE  = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [D0_IDX_SIZE-1:0] addr0,
  input  logic [D1_IDX_SIZE-1:0] addr1,
  input  logic [WIDTH-1:0]       write_data,
  input  logic                   write_en,
  input  logic                   read_en,
  output logic [WIDTH-1:0]       read_data,
  output logic                   read_done,
  output logic                   write_done,
  output logic                   addr_err
);

  localparam int unsigned Depth = D0_SIZE * D1_SIZE;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [WIDTH-1:0] mem [0:Depth-1];

  logic             in_range;
  logic [AddrW-1:0] idx;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] rd_word;

  // Stage READ_LATENCY-1 doubles as the output register, so its data holds between reads.
  logic [WIDTH-1:0]        pipe_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic                    write_done_q;
  logic                    addr_err_q;

`ifdef SEQ_MEM_PIPE_BYPASS_EN
  logic [AddrW-1:0]        pipe_idx_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_hit_q;
`endif

  assign in_range = (32'(addr0) < D0_SIZE) && (32'(addr1) < D1_SIZE);
  assign idx      = AddrW'(32'(addr0) * D1_SIZE + 32'(addr1));
  assign wr_acc   = write_en && in_range;
  assign rd_acc   = read_en && !write_en;
  assign rd_word  = in_range ? mem[idx] : '0;

  function automatic logic [WIDTH-1:0] stage_fwd(input int unsigned k);
`ifdef SEQ_MEM_PIPE_BYPASS_EN
    if (wr_acc && pipe_hit_q[k] && (pipe_idx_q[k] == idx)) begin
      return write_data;
    end
`endif
    return pipe_data_q[k];
  endfunction

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_data_q[k] <= '0;
      end
      write_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      for (int k = READ_LATENCY - 1; k >= 1; k--) begin
        pipe_valid_q[k] <= pipe_valid_q[k-1];
        if (pipe_valid_q[k-1]) begin
          pipe_data_q[k] <= stage_fwd(k - 1);
        end
      end
      pipe_valid_q[0] <= rd_acc;
      if (rd_acc) begin
        pipe_data_q[0] <= rd_word;
      end
      write_done_q <= write_en;
      addr_err_q   <= (write_en || read_en) && !in_range;
    end
  end

`ifdef SEQ_MEM_PIPE_BYPASS_EN
  // Index tags only travel through the stages a later write can still reach.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_hit_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_idx_q[k] <= '0;
      end
    end else begin
      for (int k = READ_LATENCY - 1; k >= 1; k--) begin
        pipe_hit_q[k] <= pipe_valid_q[k-1] && pipe_hit_q[k-1];
        pipe_idx_q[k] <= pipe_idx_q[k-1];
      end
      pipe_hit_q[0] <= rd_acc && in_range;
      pipe_idx_q[0] <= idx;
    end
  end
`endif

  assign read_data  = pipe_data_q[READ_LATENCY-1];
  assign read_done  = pipe_valid_q[READ_LATENCY-1];
  assign write_done = write_done_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_seq_mem_pipe_d2.sv
// Directed bench for seq_mem_pipe_d2 at read latencies 1, 3 and 4 sharing one request stream.
module tb_seq_mem_pipe_d2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr0, addr1;
  logic [31:0] write_data;
  logic        write_en, read_en;

  logic [31:0] rd1, rd3, rd4;
  logic        done1, done3, done4;
  logic        wd1, wd3, wd4;
  logic        ae1, ae3, ae4;

  int tests = 0;
  int fails = 0;
  int stray_done;
  logic [31:0] bypass_exp;

  always #5 clk = ~clk;

  seq_mem_pipe_d2 #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1), .write_data(write_data),
    .write_en(write_en), .read_en(read_en), .read_data(rd1), .read_done(done1),
    .write_done(wd1), .addr_err(ae1)
  );

  seq_mem_pipe_d2 #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1), .write_data(write_data),
    .write_en(write_en), .read_en(read_en), .read_data(rd3), .read_done(done3),
    .write_done(wd3), .addr_err(ae3)
  );

  seq_mem_pipe_d2 #(.READ_LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1), .write_data(write_data),
    .write_en(write_en), .read_en(read_en), .read_data(rd4), .read_done(done4),
    .write_done(wd4), .addr_err(ae4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [3:0] a0,
                       input logic [3:0] a1, input logic [31:0] wd);
    write_en   = we;
    read_en    = re;
    addr0      = a0;
    addr1      = a1;
    write_data = wd;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef SEQ_MEM_PIPE_BYPASS_EN
    bypass_exp = 32'hB;
`else
    bypass_exp = 32'hA;
`endif
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'd1, 4'd1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      read_en = ~read_en;
      step();
    end
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_rd3", rd3, 32'h0);
    chk_bit("rst_done1", done1, 1'b0);
    chk_bit("rst_done4", done4, 1'b0);
    chk_bit("rst_wd", wd1, 1'b0);
    chk_bit("rst_ae", ae1, 1'b0);
    reset = 1'b1;

    // Preload (1,1) and read it back at latency 1
    drive(1'b1, 1'b0, 4'd1, 4'd1, 32'hDEADBEEF);
    step();
    chk_bit("pre_wd", wd1, 1'b1);
    chk_bit("pre_ae", ae1, 1'b0);
    drive(1'b0, 1'b1, 4'd1, 4'd1, 32'h0);
    step();
    chk_bit("pre_done1", done1, 1'b1);
    chk("pre_rd1", rd1, 32'hDEADBEEF);
    chk_bit("pre_wd_clear", wd1, 1'b0);

    drive(1'b1, 1'b0, 4'd0, 4'd0, 32'd10); step();
    drive(1'b1, 1'b0, 4'd0, 4'd1, 32'd11); step();
    drive(1'b1, 1'b0, 4'd0, 4'd2, 32'd12); step();
    idle(4);

    // Back-to-back reads
    drive(1'b0, 1'b1, 4'd0, 4'd0, 32'h0); step();
    chk("str_rd1_a", rd1, 32'd10);
    drive(1'b0, 1'b1, 4'd0, 4'd1, 32'h0); step();
    chk("str_rd1_b", rd1, 32'd11);
    chk_bit("str_done3_early", done3, 1'b0);
    drive(1'b0, 1'b1, 4'd0, 4'd2, 32'h0); step();
    chk("str_rd1_c", rd1, 32'd12);
    chk_bit("str_done3_a", done3, 1'b1);
    chk("str_rd3_a", rd3, 32'd10);
    idle(1);
    chk("str_rd3_b", rd3, 32'd11);
    chk_bit("str_done4_a", done4, 1'b1);
    chk("str_rd4_a", rd4, 32'd10);
    chk_bit("str_done1_off", done1, 1'b0);
    step();
    chk_bit("str_done3_c", done3, 1'b1);
    chk("str_rd3_c", rd3, 32'd12);
    step();
    chk_bit("str_done3_end", done3, 1'b0);
    chk("str_rd3_hold", rd3, 32'd12);
    idle(3);

    // Write then read (7,7)
    drive(1'b1, 1'b0, 4'd7, 4'd7, 32'h55); step();
    chk_bit("wr_wd1", wd1, 1'b1);
    chk_bit("wr_wd3", wd3, 1'b1);
    chk_bit("wr_wd4", wd4, 1'b1);
    drive(1'b0, 1'b1, 4'd7, 4'd7, 32'h0); step();
    chk_bit("wr_done1", done1, 1'b1);
    chk("wr_rd1", rd1, 32'h55);
    idle(4);

    // Simultaneous write and read: read is dropped
    drive(1'b1, 1'b1, 4'd2, 4'd3, 32'h99); step();
    chk_bit("sim_wd", wd1, 1'b1);
    chk_bit("sim_done1", done1, 1'b0);
    idle(2);
    chk_bit("sim_done3", done3, 1'b0);
    step();
    chk_bit("sim_done4", done4, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 4'd2, 4'd3, 32'h0); step();
    chk("sim_rd1", rd1, 32'h99);
    idle(4);

    // Out-of-range accesses
    drive(1'b1, 1'b0, 4'd8, 4'd0, 32'h1); step();
    chk_bit("oor_wr_wd", wd1, 1'b1);
    chk_bit("oor_wr_ae1", ae1, 1'b1);
    chk_bit("oor_wr_ae3", ae3, 1'b1);
    chk_bit("oor_wr_ae4", ae4, 1'b1);
    idle(1);
    chk_bit("oor_ae_clear", ae1, 1'b0);
    drive(1'b0, 1'b1, 4'd0, 4'd9, 32'h0); step();
    chk_bit("oor_rd_done1", done1, 1'b1);
    chk("oor_rd1", rd1, 32'h0);
    chk_bit("oor_rd_ae", ae1, 1'b1);
    idle(2);
    chk_bit("oor_rd_done3", done3, 1'b1);
    chk("oor_rd3", rd3, 32'h0);
    idle(3);

    // Reset while reads are in flight
    drive(1'b0, 1'b1, 4'd0, 4'd0, 32'h0); step();
    drive(1'b0, 1'b1, 4'd0, 4'd1, 32'h0); step();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
    reset = 1'b0;
    #1;
    chk_bit("mid_rst_done4", done4, 1'b0);
    chk("mid_rst_rd4", rd4, 32'h0);
    step();
    reset = 1'b1;
    stray_done = 0;
    repeat (6) begin
      step();
      if (done4 || done3 || done1) stray_done++;
    end
    chk("mid_rst_no_done", 32'(stray_done), 32'd0);
    drive(1'b0, 1'b1, 4'd0, 4'd2, 32'h0); step();
    idle(3);
    chk_bit("post_rst_done4", done4, 1'b1);
    chk("post_rst_rd4", rd4, 32'd12);
    idle(2);

    // Write landing on a read still in flight
    drive(1'b1, 1'b0, 4'd0, 4'd5, 32'hA); step();
    drive(1'b0, 1'b1, 4'd0, 4'd5, 32'h0); step();
    chk("byp_rd1", rd1, 32'hA);
    drive(1'b1, 1'b0, 4'd0, 4'd5, 32'hB); step();
    chk_bit("byp_wd", wd1, 1'b1);
    idle(1);
    chk_bit("byp_done3", done3, 1'b1);
    chk("byp_rd3", rd3, bypass_exp);
    step();
    chk_bit("byp_done4", done4, 1'b1);
    chk("byp_rd4", rd4, bypass_exp);
    drive(1'b0, 1'b1, 4'd0, 4'd5, 32'h0); step();
    chk("byp_after_rd1", rd1, 32'hB);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
